fetch_prefetch_unit: RTL and testbench

Parametrised instruction-fetch front end that sits between the core's redirect sources (trap, mret, jump, fence) and the instruction memory port. It keeps up to `MAX_OUTSTANDING` pipelined in-order requests in flight and buffers returned words in a `DEPTH`-entry FIFO. It discards stale responses after a redirect and drains the memory before issuing a fenced refetch. Decode consumes the FIFO head through a valid/ready handshake.

---
 rtl/fetch_prefetch_unit_if.sv | 38 +++
 rtl/fetch_prefetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_unit_if.sv
// Bundles the redirect, instruction-memory and decode-side signals of the fetch front end.
// The fetch unit uses the master view; memory, redirect sources and decode use the slave view.
interface fetch_prefetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_addr;
  logic            redirect_fence;

  logic            mem_valid;
  logic [XLEN-1:0] mem_addr;
  logic            mem_fence;
  logic            mem_spec;
  logic            mem_instr;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_ready;

  modport master (
    input  redirect_valid, redirect_addr, redirect_fence,
    output mem_valid, mem_addr, mem_fence, mem_spec, mem_instr,
    input  mem_ready, mem_rdata,
    output out_valid, out_pc, out_instr,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_addr, redirect_fence,
    input  mem_valid, mem_addr, mem_fence, mem_spec, mem_instr,
    output mem_ready, mem_rdata,
    input  out_valid, out_pc, out_instr,
    output out_ready
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: pipelined in-order memory requests, stale-response
// discard after redirects, fence drain before refetch, and a decode-side FIFO.
module fetch_prefetch_unit #(
  parameter int unsigned    XLEN            = 32,
  parameter int unsigned    DEPTH           = 4,
  parameter int unsigned    MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_ADDR     = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  fetch_prefetch_unit_if.master bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(DEPTH);
  localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_total, r_stale, r_count;
  logic [XLEN-1:0] r_fifo_pc    [DEPTH];
  logic [XLEN-1:0] r_fifo_instr [DEPTH];
  logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [XLEN-1:0] r_tag [MAX_OUTSTANDING];
  logic [TW-1:0]   r_tag_rd, r_tag_wr;

  logic            w_redirect, w_issue, w_fence, w_resp, w_push, w_pop, w_out_valid;
  logic [CW:0]     w_inflight_sum;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TAG_LAST) ? '0 : p + TW'(1);
  endfunction

  always_comb begin
    w_redirect     = bus.redirect_valid && (r_state != IDLE);
    w_resp         = bus.mem_ready && (r_total != '0);
    w_push         = w_resp && (r_stale == '0);
    w_out_valid    = (r_count != '0);
    w_pop          = w_out_valid && bus.out_ready;
    w_inflight_sum = {1'b0, r_total} + {1'b0, r_count};
    // Issue uses registered occupancy only; a same-cycle pop gives no credit.
    w_issue        = !bus.redirect_valid
                     && ((r_state == RUN) || ((r_state == DRAIN) && (r_total == '0)))
                     && (r_total < MAX_OUT_C)
                     && (w_inflight_sum < DEPTH_C);
    w_fence        = w_issue && (r_state == DRAIN);
  end

  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.mem_valid = w_issue;
    bus.mem_addr  = w_issue ? r_fetch_pc : '0;
    bus.mem_fence = w_fence;
    bus.mem_spec  = w_redirect;
    bus.mem_instr = 1'b1;
    unique case (r_state)
      IDLE:      w_state_nxt = RUN;
      RUN, DRAIN: begin
        if (w_redirect)   w_state_nxt = bus.redirect_fence ? DRAIN : RUN;
        else if (w_fence) w_state_nxt = RUN;
      end
      default:   w_state_nxt = IDLE;
    endcase
  end

  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = r_fifo_pc[r_rd_ptr];
  assign bus.out_instr = r_fifo_instr[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fetch_pc <= RESET_ADDR;
      r_total    <= '0;
      r_stale    <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_tag_rd   <= '0;
      r_tag_wr   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) r_tag[i] <= '0;
    end else begin
      if (w_issue) begin
        r_fetch_pc      <= r_fetch_pc + XLEN'(4);
        r_tag[r_tag_wr] <= r_fetch_pc;
        r_tag_wr        <= tag_inc(r_tag_wr);
      end
      // Tags are popped for stale responses too, so the queue stays aligned with memory.
      if (w_resp) r_tag_rd <= tag_inc(r_tag_rd);
      if (w_redirect) begin
        r_fetch_pc <= bus.redirect_addr;
        r_total    <= r_total - CW'(w_resp);
        r_stale    <= r_total - CW'(w_resp);
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        r_total <= r_total + CW'(w_issue) - CW'(w_resp);
        if (w_resp && (r_stale != '0)) r_stale <= r_stale - CW'(1);
        if (w_push) begin
          r_fifo_pc[r_wr_ptr]    <= r_tag[r_tag_rd];
          r_fifo_instr[r_wr_ptr] <= bus.mem_rdata;
          r_wr_ptr               <= r_wr_ptr + PW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: directed scenarios plus random traffic,
// compared cycle by cycle with a queue-based reference model.
module tb_fetch_prefetch_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] RST_ADDR = 32'h0000_0000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fetch_prefetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_prefetch_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_ADDR(RST_ADDR)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  typedef struct { logic [31:0] addr; bit stale; } fl_t;   // model in-flight request
  typedef struct { logic [31:0] pc; logic [31:0] ins; } fe_t; // model FIFO entry
  typedef struct { logic [31:0] addr; int due; } mr_t;        // memory pending response

  fl_t m_fl[$];
  fe_t m_fifo[$];
  mr_t mem_q[$];
  logic [31:0] m_pc;
  bit          m_drain;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat = 1;
  bit spur = 1'b0;
  logic [31:0] salt = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input bit rv, input logic [31:0] ra, input bit rf, input bit ordy);
    bit   from_q, e_issue, e_ovalid, resp;
    int   tot, cnt;
    fl_t  e;
    @(negedge clock);
    bus.redirect_valid = rv;
    bus.redirect_addr  = ra;
    bus.redirect_fence = rf;
    bus.out_ready      = ordy;
    from_q = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    if (from_q) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = mem_q[0].addr ^ salt;
    end else begin
      bus.mem_ready = spur && (mem_q.size() == 0);
      bus.mem_rdata = $urandom;
    end
    #1;
    tot      = m_fl.size();
    cnt      = m_fifo.size();
    e_issue  = !rv && (!m_drain || tot == 0) && (tot < MAXO) && (tot + cnt < DEPTH);
    e_ovalid = (cnt > 0);
    chk("mem_valid", bus.mem_valid, e_issue);
    chk("mem_addr",  bus.mem_addr,  e_issue ? m_pc : 32'h0);
    chk("mem_fence", bus.mem_fence, e_issue && m_drain);
    chk("mem_spec",  bus.mem_spec,  rv);
    chk("mem_instr", bus.mem_instr, 1);
    chk("out_valid", bus.out_valid, e_ovalid);
    if (e_ovalid) begin
      chk("out_pc",    bus.out_pc,    m_fifo[0].pc);
      chk("out_instr", bus.out_instr, m_fifo[0].ins);
    end
    if (from_q) void'(mem_q.pop_front());
    if (bus.mem_valid) mem_q.push_back('{bus.mem_addr, cyc + lat});
    resp = bus.mem_ready && (tot > 0);
    if (resp) e = m_fl.pop_front();
    if (rv) begin
      m_fifo.delete();
      foreach (m_fl[i]) m_fl[i].stale = 1'b1;
      m_pc    = ra;
      m_drain = rf;
    end else begin
      if (e_ovalid && ordy) void'(m_fifo.pop_front());
      if (resp && !e.stale) m_fifo.push_back('{e.addr, bus.mem_rdata});
      if (e_issue) begin
        m_fl.push_back('{m_pc, 1'b0});
        m_pc    = m_pc + 32'd4;
        m_drain = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_addr = '0; bus.redirect_fence = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0; bus.out_ready = 1'b0;
    @(negedge clock);
    #1;
    mem_q.delete();
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_mem_addr",  bus.mem_addr,  0);
    chk("rst_mem_fence", bus.mem_fence, 0);
    chk("rst_mem_spec",  bus.mem_spec,  0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_pc",    bus.out_pc,    0);
    chk("rst_out_instr", bus.out_instr, 0);
    reset = 1'b1;
    m_fl.delete();
    m_fifo.delete();
    m_pc    = RST_ADDR;
    m_drain = 1'b0;
    cyc++;
  endtask

  // Step with no redirect until a request is issued (bounded).
  task automatic next_issue(output logic [31:0] a, output bit f, output int n);
    a = '0; f = 1'b0; n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      n++;
      if (bus.mem_valid) begin
        a = bus.mem_addr;
        f = bus.mem_fence;
        return;
      end
    end
    chk("issue_timeout", 0, 1);
  endtask

  task automatic fill_to_two();
    for (int i = 0; i < 10 && m_fl.size() < 2; i++) step(1'b0, '0, 1'b0, 1'b1);
    chk("two_in_flight", m_fl.size(), 2);
  endtask

  initial begin
    logic [31:0] a;
    bit          f;
    int          n, n_iss;
    bus.redirect_valid = 1'b0; bus.redirect_addr = '0; bus.redirect_fence = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0; bus.out_ready = 1'b0;

    // Streaming, 1-cycle memory latency, word = address
    do_reset();
    lat = 1; salt = '0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      chk("stream_mv",   bus.mem_valid, 1);
      chk("stream_addr", bus.mem_addr, 32'(4 * k));
      if (k >= 2) begin
        chk("stream_ov",    bus.out_valid, 1);
        chk("stream_pc",    bus.out_pc,    32'(4 * (k - 2)));
        chk("stream_instr", bus.out_instr, 32'(4 * (k - 2)));
      end
    end

    // Backpressure: FIFO fills to DEPTH, then drains in order and issue resumes
    do_reset();
    n_iss = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      if (bus.mem_valid) n_iss++;
    end
    chk("bp_issued", n_iss, DEPTH);
    chk("bp_mv_held", bus.mem_valid, 0);
    spur = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    spur = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      chk("bp_drain_pc", bus.out_pc, 32'(4 * k));
      chk("bp_resume",   bus.mem_valid, (k >= 1));
    end

    // Redirect with two requests in flight: both late responses are dropped
    do_reset();
    lat = 3; salt = 32'h1357_9BDF;
    fill_to_two();
    step(1'b1, 32'h100, 1'b0, 1'b1);
    chk("redir_spec", bus.mem_spec, 1);
    chk("redir_mv",   bus.mem_valid, 0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("redir_ov_after", bus.out_valid, 0);
    for (int i = 0; i < 12 && !bus.out_valid; i++) step(1'b0, '0, 1'b0, 1'b1);
    chk("redir_first_pc", bus.out_pc, 32'h100);

    // Fence: drain both in-flight responses, then one fenced request
    do_reset();
    fill_to_two();
    step(1'b1, 32'h200, 1'b1, 1'b1);
    chk("fence_redir_mv", bus.mem_valid, 0);
    next_issue(a, f, n);
    chk("fence_wait",  n, 3);
    chk("fence_addr",  a, 32'h200);
    chk("fence_bit",   f, 1);
    next_issue(a, f, n);
    chk("fence_next_addr", a, 32'h204);
    chk("fence_next_bit",  f, 0);

    // Address wrap
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    next_issue(a, f, n);
    chk("wrap_addr0", a, 32'hFFFF_FFFC);
    next_issue(a, f, n);
    chk("wrap_addr1", a, 32'h0000_0000);

    // Reset while the FIFO is full, then fetch restarts at the reset address
    lat = 1;
    for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b0, 1'b0);
    chk("full_before_rst", bus.out_valid, 1);
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    chk("restart_mv",   bus.mem_valid, 1);
    chk("restart_addr", bus.mem_addr, RST_ADDR);

    // Random traffic against the model
    for (int k = 0; k < 2000; k++) begin
      if (k % 100 == 0) begin
        lat  = $urandom_range(1, 4);
        salt = $urandom;
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(($urandom_range(0, 99) < 5), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) < 70));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
